boot_loader: RTL and testbench
==============================

// Module: boot_loader
// PURPOSE
//  Loads a program into the CPU's instruction memory, then issues the CPU's INT/entryPoint boot request.
//  Words arrive on a valid/ready stream. Each word is written to consecutive word addresses.
//  After the last write commits, INT pulses with entryPoint. This replaces the hand-driven boot sequence.
// PARAMETERS
//  ADDR_W     32    width of mem_addr, base_addr, entry_addr and entryPoint
//  DATA_W     32    instruction/data word width
//  CNT_W      16    width of word_count and words_loaded
//  TIMEOUT    1024  max consecutive LOAD cycles without a handshake before ERR (>=2)
//  INT_CYCLES 1     number of cycles INT is held high in LAUNCH (>=1)
// PORTS
//  clk         in   1       system clock, rising edge
//  rst_n       in   1       synchronous active-low reset
//  start       in   1       begin a load; sampled only in IDLE, DONE and ERR
//  base_addr   in   ADDR_W  byte address of the first word; must be word-aligned
//  entry_addr  in   ADDR_W  PC value delivered on entryPoint at launch
//  word_count  in   CNT_W   number of words to load; 0 means launch only
//  in_valid    in   1       stream word valid
//  in_ready    out  1       loader accepts a word this cycle
//  in_data     in   DATA_W  stream word
//  mem_we      out  1       instruction memory write strobe (one cycle per word)
//  mem_addr    out  ADDR_W  write byte address
//  mem_wdata   out  DATA_W  write data
//  INT         out  1       boot request to the PC mux
//  entryPoint  out  ADDR_W  boot PC, valid while INT=1
//  busy        out  1       high in LOAD and LAUNCH
//  done        out  1       high in DONE
//  error       out  1       high in ERR
//  checksum    out  DATA_W  running XOR of all accepted words
//  words_loaded out CNT_W   number of words accepted in the current load
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): FSM goes to IDLE. Every output goes to 0.
//   A reset in the middle of a load abandons it. Memory already written is left as is.
//  States: IDLE, LOAD, LAUNCH, DONE, ERR.
//  IDLE/DONE/ERR + start=1:
//   - Latch base_addr, entry_addr and word_count. Clear checksum, words_loaded, done and error.
//   - base_addr[1:0]!=0 -> ERR.
//   - Else word_count==0 -> LAUNCH.
//   - Else -> LOAD.
//  LOAD:
//   - in_ready=1.
//   - A handshake is in_valid&in_ready at a clk edge.
//   - On the handshake edge, register mem_we=1, mem_addr=base+4*words_loaded (mod 2^ADDR_W, wraps silently) and mem_wdata=in_data.
//   - Write latency: exactly 1 cycle after the handshake. mem_we is 0 in every other cycle.
//   - On the same edge, checksum ^= in_data and words_loaded++.
//   - On the edge of the last handshake: in_ready drops in the next cycle and the FSM goes to LAUNCH.
//   - The last mem_we is therefore high in the first LAUNCH cycle.
//  LAUNCH:
//   - INT=1 and entryPoint=entry_addr for INT_CYCLES cycles.
//   - INT rises in the first LAUNCH cycle, the same cycle as the final write strobe.
//   - Then -> DONE. INT returns to 0. entryPoint holds its value.
//  DONE: done=1, held until start or reset.
//  ERR: error=1, sticky until start or reset. in_ready=0 and INT=0.
//  Watchdog:
//   - Counts consecutive LOAD cycles without a handshake. It clears on every handshake.
//   - When the count reaches TIMEOUT -> ERR. No INT is issued.
//   - A handshake in that same cycle wins and the counter clears.
//  start is ignored in LOAD and LAUNCH.
//  in_valid outside LOAD is ignored; no word is consumed.
//  start and rst_n=0 in the same cycle: reset wins.
// STRUCTURE
//  Shared package boot_pkg:
//   - state encoding BL_IDLE..BL_ERR (3 bits)
//   - WORD_STRIDE=4
//   - shared with yPC for the INT/entryPoint handshake
//  Sub-module boot_watchdog: CNT of clog2(TIMEOUT+1) bits; inputs en, clr; output expired.
//  The FSM, address counter and checksum live in boot_loader.
// TESTING
//  1) base=0x80, entry=0x80, count=3, words A,B,C back-to-back
//     -> writes 0x80/0x84/0x88, each one cycle after its handshake
//     -> INT high 1 cycle with entryPoint=0x80, then done=1, checksum=A^B^C.
//  2) count=0, entry=0x100
//     -> no mem_we; INT pulses in the cycle after start with entryPoint=0x100; then done.
//  3) base=0x82
//     -> error=1 the cycle after start; in_ready stays 0.
//     -> start again with base=0x80 clears error and loads normally.
//  4) count=2, one word, then in_valid=0 for TIMEOUT cycles
//     -> ERR, INT never asserted, words_loaded=1.
//  5) base=0xFFFFFFFC, count=2 -> writes at 0xFFFFFFFC then 0x00000000; launch occurs.
//  6) rst_n=0 mid-LOAD after 2 of 4 words
//     -> all outputs 0 next cycle, FSM in IDLE.
//     -> start pulsed during LOAD/LAUNCH is ignored.

Source files
------------

// File: rtl/boot_pkg.sv
// boot_pkg: boot FSM state encoding and word stride shared by the loader and the PC mux.
package boot_pkg;
  typedef enum logic [2:0] {BL_IDLE, BL_LOAD, BL_LAUNCH, BL_DONE, BL_ERR} bl_state_t;
  localparam int WORD_STRIDE = 4;
endpackage

// File: rtl/boot_watchdog.sv
// boot_watchdog: counts consecutive enabled cycles and flags the TIMEOUT-th one.
module boot_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (en) cnt <= cnt + CW'(1);
  assign expired = en && cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/boot_loader.sv
// boot_loader: streams a program into instruction memory, then raises INT with entryPoint.
module boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1024,
  parameter int INT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] entry_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              INT,
  output logic [ADDR_W-1:0] entryPoint,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum,
  output logic [CNT_W-1:0]  words_loaded
);
  localparam int LW = $clog2(INT_CYCLES + 1);
  bl_state_t state, next;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0] count_q;
  logic [LW-1:0] lcnt;
  logic idle, hs, last, expired;
  assign idle = state == BL_IDLE || state == BL_DONE || state == BL_ERR;
  assign hs = in_valid && in_ready;
  assign last = words_loaded + CNT_W'(1) == count_q;
  assign in_ready = state == BL_LOAD;
  assign INT = state == BL_LAUNCH;
  assign busy = in_ready || INT;
  assign done = state == BL_DONE;
  assign error = state == BL_ERR;
  boot_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .rst_n(rst_n),
    .en(in_ready && !in_valid),
    .clr(!in_ready || in_valid),
    .expired(expired)
  );
  always_ff @(posedge clk)
    if (!rst_n) state <= BL_IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      BL_LOAD:   next = hs && last ? BL_LAUNCH : expired ? BL_ERR : BL_LOAD;
      BL_LAUNCH: next = lcnt == LW'(INT_CYCLES - 1) ? BL_DONE : BL_LAUNCH;
      default:   if (start) next = base_addr[1:0] != 2'b00 ? BL_ERR : word_count == '0 ? BL_LAUNCH : BL_LOAD;
    endcase
  end
  // addr_q runs one word ahead of the registered mem_addr
  always_ff @(posedge clk)
    if (!rst_n) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      entryPoint   <= '0;
      checksum     <= '0;
      words_loaded <= '0;
      addr_q       <= '0;
      count_q      <= '0;
      lcnt         <= '0;
    end else begin
      mem_we <= 1'b0;
      lcnt   <= INT ? lcnt + LW'(1) : '0;
      if (idle && start) begin
        addr_q       <= base_addr;
        entryPoint   <= entry_addr;
        count_q      <= word_count;
        checksum     <= '0;
        words_loaded <= '0;
      end else if (hs) begin
        mem_we       <= 1'b1;
        mem_addr     <= addr_q;
        mem_wdata    <= in_data;
        addr_q       <= addr_q + ADDR_W'(WORD_STRIDE);
        checksum     <= checksum ^ in_data;
        words_loaded <= words_loaded + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed loads; a monitor checks writes and INT pulses against a scoreboard queue.
module tb_boot_loader;
  localparam int TO = 16;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [31:0] base_addr = 0, entry_addr = 0, in_data = 0;
  logic [15:0] word_count = 0;
  logic in_ready, mem_we, INT, busy, done, error;
  logic [31:0] mem_addr, mem_wdata, entryPoint, checksum;
  logic [15:0] words_loaded;
  int checks = 0, passed = 0;
  logic hs_q = 0;
  typedef struct {bit is_int; logic [31:0] addr; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t e;

  boot_loader #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .entry_addr(entry_addr),
    .word_count(word_count), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .INT(INT), .entryPoint(entryPoint),
    .busy(busy), .done(done), .error(error), .checksum(checksum), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic push_w(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{1'b0, a, d});
  endtask

  task automatic push_i(input logic [31:0] a);
    exp_q.push_back('{1'b1, a, 32'h0});
  endtask

  task automatic do_start(input logic [31:0] b, input logic [31:0] en, input logic [15:0] n);
    base_addr = b; entry_addr = en; word_count = n; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1; in_data = d;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!done && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_wait", done, 1);
  endtask

  always @(posedge clk) hs_q <= rst_n && in_valid && in_ready;

  always @(negedge clk) begin
    if (mem_we || hs_q) begin
      chk("we_latency", mem_we, hs_q);
      if (mem_we) begin
        if (exp_q.size() == 0 || exp_q[0].is_int) chk("unexp_we", mem_we, 0);
        else begin
          e = exp_q.pop_front();
          chk("we_addr", mem_addr, e.addr);
          chk("we_data", mem_wdata, e.data);
        end
      end
    end
    if (INT) begin
      if (exp_q.size() == 0 || !exp_q[0].is_int) chk("unexp_int", INT, 0);
      else begin
        e = exp_q.pop_front();
        chk("int_entry", entryPoint, e.addr);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_int", INT, 0);
    chk("rst_flags", {busy, done, error}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_entry", entryPoint, 0);
    chk("rst_sum", checksum, 0);
    chk("rst_cnt", words_loaded, 0);
    rst_n = 1;
    @(posedge clk); #1;
    // 1: three back-to-back words, start during LAUNCH ignored
    push_w(32'h80, 32'hDEADBEEF);
    push_w(32'h84, 32'h12345678);
    push_w(32'h88, 32'h0F0F0F0F);
    push_i(32'h80);
    do_start(32'h80, 32'h80, 3);
    chk("t1_ready", in_ready, 1);
    send(32'hDEADBEEF);
    send(32'h12345678);
    send(32'h0F0F0F0F);
    chk("t1_int", INT, 1);
    chk("t1_last_we", mem_we, 1);
    chk("t1_ready_drop", in_ready, 0);
    base_addr = 32'h82; word_count = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("t1_done", done, 1);
    chk("t1_err", error, 0);
    chk("t1_int_low", INT, 0);
    chk("t1_sum", checksum, 32'hC396E798);
    chk("t1_cnt", words_loaded, 3);
    chk("t1_entry_hold", entryPoint, 32'h80);
    // 2: launch only
    push_i(32'h100);
    do_start(32'h40, 32'h100, 0);
    chk("t2_int", INT, 1);
    chk("t2_entry", entryPoint, 32'h100);
    @(posedge clk); #1;
    chk("t2_done", done, 1);
    // 3: misaligned base, then recovery
    do_start(32'h82, 32'h80, 1);
    chk("t3_err", error, 1);
    chk("t3_ready", in_ready, 0);
    in_valid = 1; in_data = 32'h55;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 0;
    chk("t3_ready_hold", in_ready, 0);
    chk("t3_cnt", words_loaded, 0);
    push_w(32'h80, 32'hA5A5A5A5);
    push_i(32'h200);
    do_start(32'h80, 32'h200, 1);
    chk("t3_err_clr", error, 0);
    chk("t3_busy", busy, 1);
    send(32'hA5A5A5A5);
    wait_done(10);
    chk("t3_sum", checksum, 32'hA5A5A5A5);
    // 4: watchdog expiry after one word
    push_w(32'h1000, 32'h11111111);
    do_start(32'h1000, 32'h300, 2);
    send(32'h11111111);
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("t4_not_yet", error, 0);
    chk("t4_busy", busy, 1);
    @(posedge clk); #1;
    chk("t4_err", error, 1);
    chk("t4_cnt", words_loaded, 1);
    chk("t4_int", INT, 0);
    // 5: address wrap
    push_w(32'hFFFFFFFC, 32'h1);
    push_w(32'h0, 32'h2);
    push_i(32'h80);
    do_start(32'hFFFFFFFC, 32'h80, 2);
    send(32'h1);
    send(32'h2);
    wait_done(10);
    chk("t5_sum", checksum, 32'h3);
    // 6: start ignored in LOAD, reset mid-load
    push_w(32'h2000, 32'hCAFE0001);
    push_w(32'h2004, 32'hCAFE0002);
    do_start(32'h2000, 32'h400, 4);
    send(32'hCAFE0001);
    send(32'hCAFE0002);
    base_addr = 32'h82; word_count = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("t6_busy", busy, 1);
    chk("t6_err", error, 0);
    chk("t6_cnt", words_loaded, 2);
    rst_n = 0;
    @(posedge clk); #1;
    chk("t6_flags", {busy, done, error, in_ready, INT, mem_we}, 0);
    chk("t6_cnt_rst", words_loaded, 0);
    chk("t6_sum_rst", checksum, 0);
    chk("t6_addr_rst", mem_addr, 0);
    chk("t6_entry_rst", entryPoint, 0);
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
